// File: rtl/ballot_console.sv
// rtl/ballot_console.sv - ballot input initiator: debounced panel buttons to one-hot voter bus and confirm strobe
// BALLOT_TIMEOUT_EN adds an armed-ballot lifetime and the timeout_flag port.
module ballot_console #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETUP_CYCLES    = 2,
  parameter int STROBE_CYCLES   = 2,
  parameter int HOLD_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ballot_issue,
  input  logic       ballot_cancel,
  input  logic [3:0] btn_cand,
  input  logic       btn_cast,
  output logic [3:0] voter,
  output logic       confirm,
  output logic       ready,
  output logic       armed,
  output logic [3:0] sel_led,
  output logic       vote_done,
  output logic [7:0] ballots_cast
`ifdef BALLOT_TIMEOUT_EN
  ,
  output logic       timeout_flag
`endif
);

  localparam int DB_EFF     = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int SETUP_EFF  = (SETUP_CYCLES < 1) ? 1 : SETUP_CYCLES;
  localparam int STROBE_EFF = (STROBE_CYCLES < 1) ? 1 : STROBE_CYCLES;
  localparam int HOLD_EFF   = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int TO_EFF     = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;

  localparam int TMAX_A  = (SETUP_EFF > STROBE_EFF) ? SETUP_EFF : STROBE_EFF;
  localparam int TMAX_B  = (TMAX_A > HOLD_EFF) ? TMAX_A : HOLD_EFF;
  localparam int CNT_MAX = (TMAX_B > TO_EFF) ? TMAX_B : TO_EFF;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = $clog2(DB_EFF + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DB_EFF - 1);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_EFF - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_EFF - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_EFF - 1);
`ifdef BALLOT_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LD     = CW'(TO_EFF - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  // Bit 4 is the cast button, bits 3:0 the candidate buttons.
  logic [4:0]           sync1_q, sync2_q;
  logic [4:0]           level_q, level_d;
  logic [4:0][DW-1:0]   db_cnt_q, db_cnt_d;
  logic [4:0]           rise;
  logic [3:0]           cand_rise;
  logic                 cast_rise;
  logic                 cand_single;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           sel_q;
  logic [3:0]           voter_q;
  logic                 confirm_q;
  logic                 ready_q;
  logic                 armed_q;
  logic                 vote_done_q;
  logic [7:0]           ballots_q;
`ifdef BALLOT_TIMEOUT_EN
  logic                 timeout_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= {btn_cast, btn_cand};
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Any sample agreeing with the accepted level restarts that button's count.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise        = level_d & ~level_q;
  assign cand_rise   = rise[3:0];
  assign cast_rise   = rise[4];
  assign cand_single = (cand_rise != 4'd0) && ((cand_rise & (cand_rise - 4'd1)) == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      voter_q     <= '0;
      confirm_q   <= 1'b0;
      ready_q     <= 1'b1;
      armed_q     <= 1'b0;
      vote_done_q <= 1'b0;
      ballots_q   <= '0;
`ifdef BALLOT_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      vote_done_q <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (ballot_issue) begin
            state_q <= S_ARMED;
            sel_q   <= '0;
            ready_q <= 1'b0;
            armed_q <= 1'b1;
`ifdef BALLOT_TIMEOUT_EN
            cnt_q   <= TO_LD;
`endif
          end
        end
        S_ARMED: begin
          if (ballot_cancel) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            ready_q <= 1'b1;
            armed_q <= 1'b0;
          end else if (cast_rise && (sel_q != 4'd0)) begin
            state_q <= S_SETUP;
            voter_q <= sel_q;
            cnt_q   <= SETUP_LD;
            armed_q <= 1'b0;
          end else begin
            if (cand_single) begin
              sel_q <= cand_rise;
            end
`ifdef BALLOT_TIMEOUT_EN
            if (cand_rise != 4'd0) begin
              cnt_q <= TO_LD;
            end else if (cnt_q == '0) begin
              state_q   <= S_IDLE;
              sel_q     <= '0;
              ready_q   <= 1'b1;
              armed_q   <= 1'b0;
              timeout_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
`endif
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            state_q   <= S_STROBE;
            confirm_q <= 1'b1;
            cnt_q     <= STROBE_LD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_STROBE: begin
          if (cnt_q == '0) begin
            state_q   <= S_HOLD;
            confirm_q <= 1'b0;
            cnt_q     <= HOLD_LD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_q     <= S_IDLE;
            voter_q     <= '0;
            sel_q       <= '0;
            ready_q     <= 1'b1;
            vote_done_q <= 1'b1;
            if (ballots_q != 8'hFF) begin
              ballots_q <= ballots_q + 8'd1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          voter_q   <= '0;
          confirm_q <= 1'b0;
          sel_q     <= '0;
          ready_q   <= 1'b1;
          armed_q   <= 1'b0;
        end
      endcase
    end
  end

  assign voter        = voter_q;
  assign confirm      = confirm_q;
  assign ready        = ready_q;
  assign armed        = armed_q;
  assign sel_led      = sel_q;
  assign vote_done    = vote_done_q;
  assign ballots_cast = ballots_q;
`ifdef BALLOT_TIMEOUT_EN
  assign timeout_flag = timeout_q;
`endif

endmodule

// File: tb/tb_ballot_console.sv
// tb/tb_ballot_console.sv - directed and randomized bench for ballot_console against a behavioural model
module tb_ballot_console;

  localparam int DB  = 4;
  localparam int SU  = 2;
  localparam int ST  = 3;
  localparam int HO  = 2;
  localparam int TO  = 50;
  localparam int LEN = SU + ST + HO;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ballot_issue = 1'b0;
  logic       ballot_cancel = 1'b0;
  logic [3:0] btn_cand = 4'd0;
  logic       btn_cast = 1'b0;
  logic [3:0] voter;
  logic       confirm;
  logic       ready;
  logic       armed;
  logic [3:0] sel_led;
  logic       vote_done;
  logic [7:0] ballots_cast;
`ifdef BALLOT_TIMEOUT_EN
  logic       timeout_flag;
`endif

  ballot_console #(
    .DEBOUNCE_CYCLES(DB),
    .SETUP_CYCLES(SU),
    .STROBE_CYCLES(ST),
    .HOLD_CYCLES(HO),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ballot_issue(ballot_issue),
    .ballot_cancel(ballot_cancel),
    .btn_cand(btn_cand),
    .btn_cast(btn_cast),
    .voter(voter),
    .confirm(confirm),
    .ready(ready),
    .armed(armed),
    .sel_led(sel_led),
    .vote_done(vote_done),
    .ballots_cast(ballots_cast)
`ifdef BALLOT_TIMEOUT_EN
    ,
    .timeout_flag(timeout_flag)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string nm, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, expv, $time);
    end
  endfunction

  // Behavioural model: a ballot is idle, armed, or in transaction k (1..LEN edges after the cast).
  typedef enum {M_IDLE, M_ARMED, M_BUSY} mphase_t;
  mphase_t    m_phase;
  logic [3:0] m_sel;
  int         m_k;
  int         m_count;
  logic [4:0] m_level;
  logic [4:0] rawq[$];
  int         edge_no;
  int         m_deadline;
  logic [3:0] exp_voter, exp_sel;
  logic       exp_confirm, exp_ready, exp_armed, exp_done, exp_tflag;
  logic [7:0] exp_count;

  function automatic void mreset();
    m_phase = M_IDLE; m_sel = 4'd0; m_k = 0; m_count = 0; m_level = 5'd0;
    edge_no = 0; m_deadline = 0;
    rawq.delete();
    for (int j = 0; j < DB + 1; j++) rawq.push_back(5'd0);
    exp_voter = 4'd0; exp_sel = 4'd0; exp_confirm = 1'b0; exp_ready = 1'b1;
    exp_armed = 1'b0; exp_done = 1'b0; exp_tflag = 1'b0; exp_count = 8'd0;
  endfunction

  function automatic void mstep();
    logic [4:0] r;
    logic [3:0] cand_r;
    logic       cast_r;
    bit         flip;
    edge_no++;
    rawq.push_back({btn_cast, btn_cand});
    r = 5'd0;
    // A button level flips once the synchronized samples of the last DB edges all disagree with it.
    for (int b = 0; b < 5; b++) begin
      flip = 1'b1;
      for (int j = 0; j < DB; j++) if (rawq[j][b] == m_level[b]) flip = 1'b0;
      if (flip) begin
        m_level[b] = ~m_level[b];
        if (m_level[b]) r[b] = 1'b1;
      end
    end
    void'(rawq.pop_front());
    cand_r = r[3:0];
    cast_r = r[4];
    exp_done = 1'b0;
    exp_tflag = 1'b0;
    case (m_phase)
      M_IDLE: if (ballot_issue) begin
        m_phase = M_ARMED; m_sel = 4'd0; m_deadline = edge_no + TO;
      end
      M_ARMED: begin
        if (ballot_cancel) begin
          m_phase = M_IDLE; m_sel = 4'd0;
        end else if (cast_r && m_sel != 4'd0) begin
          m_phase = M_BUSY; m_k = 1;
        end else if (cand_r != 4'd0) begin
          if ($countones(cand_r) == 1) m_sel = cand_r;
          m_deadline = edge_no + TO;
        end
`ifdef BALLOT_TIMEOUT_EN
        else if (edge_no == m_deadline) begin
          m_phase = M_IDLE; m_sel = 4'd0; exp_tflag = 1'b1;
        end
`endif
      end
      default: begin
        m_k++;
        if (m_k > LEN) begin
          m_phase = M_IDLE; m_sel = 4'd0; exp_done = 1'b1;
          if (m_count < 255) m_count++;
        end
      end
    endcase
    exp_voter   = (m_phase == M_BUSY) ? m_sel : 4'd0;
    exp_confirm = (m_phase == M_BUSY) && (m_k > SU) && (m_k <= SU + ST);
    exp_ready   = (m_phase == M_IDLE);
    exp_armed   = (m_phase == M_ARMED);
    exp_sel     = m_sel;
    exp_count   = 8'(m_count);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) mreset();
    else mstep();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("voter", voter, exp_voter);
      chk("confirm", confirm, exp_confirm);
      chk("ready", ready, exp_ready);
      chk("armed", armed, exp_armed);
      chk("sel_led", sel_led, exp_sel);
      chk("vote_done", vote_done, exp_done);
      chk("ballots_cast", ballots_cast, exp_count);
`ifdef BALLOT_TIMEOUT_EN
      chk("timeout_flag", timeout_flag, exp_tflag);
`endif
    end
  end

  int   conf_rises = 0;
  logic conf_prev = 1'b0;
  always @(negedge clk) begin
    if (confirm && !conf_prev) conf_rises++;
    conf_prev = confirm;
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_issue();
    ballot_issue = 1'b1; cyc(1); ballot_issue = 1'b0;
  endtask

  task automatic pulse_cancel();
    ballot_cancel = 1'b1; cyc(1); ballot_cancel = 1'b0;
  endtask

  task automatic press_cand(input logic [3:0] m);
    btn_cand = m; cyc(8); btn_cand = 4'd0; cyc(8);
  endtask

  task automatic press_cast();
    btn_cast = 1'b1; cyc(8); btn_cast = 1'b0; cyc(8);
  endtask

  task automatic do_reset();
    rst = 1'b1; #4; rst = 1'b0;
  endtask

  task automatic wait_confirm(string nm);
    int n;
    n = 0;
    while (!confirm && n < 30) begin cyc(1); n++; end
    chk(nm, confirm, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, nc, nd, fv, fc, c0, b0, k, found, idx;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    #5;
    chk("rst_ready", ready, 1);
    chk("rst_voter", voter, 0);
    chk("rst_count", ballots_cast, 0);
    #7 rst = 1'b0;

    // Basic vote on candidate 2.
    pulse_issue();
    press_cand(4'b0100);
    chk("s1_sel", sel_led, 4'b0100);
    nv = 0; nc = 0; nd = 0; fv = -1; fc = -1;
    btn_cast = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (voter == 4'b0100) begin nv++; if (fv < 0) fv = i; end
      if (confirm) begin nc++; if (fc < 0) fc = i; end
      if (vote_done) nd++;
    end
    btn_cast = 1'b0;
    cyc(8);
    chk("s1_voter_cycles", nv, 7);
    chk("s1_confirm_cycles", nc, 3);
    chk("s1_setup_gap", fc - fv, 2);
    chk("s1_done_pulses", nd, 1);
    chk("s1_count", ballots_cast, 1);
    chk("s1_ready", ready, 1);

    // Bounce rejection.
    pulse_issue();
    for (int i = 0; i < 10; i++) begin btn_cand[1] = ~btn_cand[1]; cyc(2); end
    chk("s2_bounce_sel", sel_led, 0);
    btn_cand[1] = 1'b1;
    cyc(10);
    chk("s2_stable_sel", sel_led, 4'b0010);
    btn_cand = 4'd0; cyc(8);
    pulse_cancel();

    // Invalid inputs.
    c0 = conf_rises;
    press_cand(4'b0001);
    press_cast();
    chk("s3_idle_confirm", conf_rises - c0, 0);
    pulse_issue();
    press_cand(4'b1001);
    chk("s3_multi_sel", sel_led, 0);
    press_cast();
    chk("s3_nosel_confirm", conf_rises - c0, 0);
    chk("s3_still_armed", armed, 1);
    pulse_cancel();
    chk("s3_ready", ready, 1);

    // Cancel, then atomicity of a running transaction.
    pulse_issue();
    press_cand(4'b1000);
    chk("s4_sel", sel_led, 4'b1000);
    c0 = conf_rises;
    pulse_cancel();
    chk("s4_cancel_ready", ready, 1);
    chk("s4_cancel_sel", sel_led, 0);
    press_cast();
    chk("s4_cancel_confirm", conf_rises - c0, 0);
    b0 = ballots_cast;
    pulse_issue();
    press_cand(4'b0001);
    btn_cast = 1'b1;
    wait_confirm("s4_confirm_seen");
    ballot_cancel = 1'b1; ballot_issue = 1'b1;
    cyc(1);
    ballot_cancel = 1'b0; ballot_issue = 1'b0;
    cyc(10);
    btn_cast = 1'b0;
    cyc(8);
    chk("s4_count", ballots_cast, b0 + 1);
    chk("s4_pulses", conf_rises - c0, 1);
    chk("s4_ready", ready, 1);

    // Saturation, then reset in the middle of a strobe.
    do_reset();
    for (int v = 0; v < 256; v++) begin
      pulse_issue();
      press_cand(4'(1 << $urandom_range(3, 0)));
      press_cast();
    end
    chk("s5_saturated", ballots_cast, 255);
    pulse_issue();
    press_cand(4'b0010);
    btn_cast = 1'b1;
    wait_confirm("s5_confirm_seen");
    #1 rst = 1'b1;
    #1;
    chk("s5_rst_confirm", confirm, 0);
    chk("s5_rst_voter", voter, 0);
    chk("s5_rst_count", ballots_cast, 0);
    chk("s5_rst_ready", ready, 1);
    #2 rst = 1'b0;
    btn_cast = 1'b0;
    cyc(8);

`ifdef BALLOT_TIMEOUT_EN
    // Armed ballot expires; a candidate press restarts its lifetime.
    do_reset();
    cyc(1);
    ballot_issue = 1'b1;
    @(posedge clk); #2;
    ballot_issue = 1'b0;
    k = 0; found = 0;
    while (k < 70 && found == 0) begin
      @(negedge clk); k++;
      if (timeout_flag) found = k;
    end
    chk("s6_expiry", found, 51);
    chk("s6_ready", ready, 1);
    ballot_issue = 1'b1;
    @(posedge clk); #2;
    ballot_issue = 1'b0;
    k = 0; found = 0;
    while (k < 120 && found == 0) begin
      @(negedge clk); k++;
      if (k == 41) btn_cand = 4'b0100;
      if (k == 60) btn_cand = 4'd0;
      if (timeout_flag) found = k;
    end
    chk("s6_extended", found, 97);
    cyc(4);
`endif

    // Randomized traffic; every cycle is checked against the model.
    for (int i = 0; i < 6000; i++) begin
      ballot_issue  = ($urandom_range(15, 0) == 0);
      ballot_cancel = ($urandom_range(63, 0) == 0);
      if ($urandom_range(5, 0) == 0) begin
        idx = $urandom_range(3, 0);
        btn_cand[idx] = ~btn_cand[idx];
      end
      if ($urandom_range(9, 0) == 0) btn_cast = ~btn_cast;
      if (i == 3000) begin
        #1 rst = 1'b1; #3 rst = 1'b0;
      end
      cyc(1);
    end
    ballot_issue = 1'b0; ballot_cancel = 1'b0; btn_cand = 4'd0; btn_cast = 1'b0;
    cyc(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ballot_console.md
Name: ballot_console

Overview:
- Voter-side initiator for the voting machine's ballot input interface.
- Takes raw candidate and cast buttons plus an officer "issue ballot" pulse.
- Debounces the buttons, lets exactly one vote through per issued ballot, and drives the machine's one-hot voter bus and confirm strobe with guaranteed setup/strobe/hold timing.
- Sits between the front-panel buttons and the voting machine's voter[3:0]/confirm pins.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples needed before a button level is accepted.
- SETUP_CYCLES, 2: cycles voter is held valid with confirm low before the strobe.
- STROBE_CYCLES, 2: cycles confirm is held high.
- HOLD_CYCLES, 2: cycles voter stays valid after confirm falls.
- TIMEOUT_CYCLES, 1000: armed-ballot lifetime; used only with BALLOT_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ballot_issue  in  1  officer pulse, clean and synchronous, arms one ballot.
- ballot_cancel  in  1  officer pulse, clean and synchronous, voids an armed ballot.
- btn_cand  in  4  raw asynchronous candidate buttons, bit i = candidate i.
- btn_cast  in  1  raw asynchronous cast button.
- voter  out  4  one-hot candidate select to the voting machine.
- confirm  out  1  confirm strobe to the voting machine.
- ready  out  1  high in IDLE (no ballot armed).
- armed  out  1  high in ARMED.
- sel_led  out  4  current latched selection, for panel LEDs.
- vote_done  out  1  one-cycle pulse when a vote transaction completes.
- ballots_cast  out  8  completed votes, saturating at 255.

Behaviour:
- Reset values (asynchronous): state=IDLE, voter=0, confirm=0, ready=1, armed=0, sel_led=0, vote_done=0, ballots_cast=0. Synchronizers, debounce counters and debounced levels also clear to 0.
- Input conditioning:
  - Each of the 5 raw buttons passes through a 2-flop synchronizer, then a per-button counter.
  - The debounced level changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce resets that button's counter.
  - A rising edge is a debounced 0->1 transition, one cycle wide.
- All outputs are registered.
- States: IDLE, ARMED, SETUP, STROBE, HOLD. A down-counter sized by $clog2 of the largest parameter + 1 times each timed state.
- IDLE:
  - Button edges are ignored and voter=0.
  - ballot_issue -> ARMED, sel cleared to 0.
- ARMED:
  - A candidate rising edge on exactly one bit sets sel to that one-hot value; a later press replaces it.
  - Rising edges on two or more bits in the same cycle are ignored (sel unchanged).
  - A cast rising edge with sel!=0 -> SETUP. A cast edge with sel==0 is ignored.
  - ballot_cancel -> IDLE, sel cleared, no vote issued.
  - If cast and cancel arrive in the same cycle, cancel wins.
  - ballot_issue is ignored.
- SETUP: voter=sel, confirm=0, for SETUP_CYCLES cycles, then -> STROBE.
- STROBE: voter=sel, confirm=1, for STROBE_CYCLES cycles, then -> HOLD.
- HOLD: voter=sel, confirm=0, for HOLD_CYCLES cycles, then -> IDLE. On that exit cycle:
  - voter and sel clear to 0.
  - vote_done pulses.
  - ballots_cast increments unless already 255.
- SETUP/STROBE/HOLD are atomic: ballot_issue, ballot_cancel and all button edges are ignored.
- Timing: the cast edge seen in cycle N gives voter valid at N+1 and confirm high at N+1+SETUP_CYCLES. Confirm is high exactly STROBE_CYCLES cycles; voter stays stable HOLD_CYCLES cycles after confirm falls.
- Guarantee: voter is never non-one-hot. Exactly one confirm pulse is produced per issued ballot, at most.
- rst mid-transaction aborts immediately: confirm and voter drop to 0 and no count increments.
- A parameter value of 0 is treated as 1.

Optional Feature:
- Macro: BALLOT_TIMEOUT_EN.
- Defined:
  - ARMED runs a counter loaded with TIMEOUT_CYCLES on entry and reloaded on every candidate rising edge.
  - On expiry: return to IDLE, clear sel, and pulse the extra output port timeout_flag for one cycle. The port exists only under the macro.
  - A cast edge arriving in the expiry cycle wins over the timeout.
- Undefined: an armed ballot stays armed indefinitely; no timeout logic and no timeout_flag port.

Test Plan:
- Parameters DEBOUNCE=4, SETUP=2, STROBE=3, HOLD=2 for all scenarios.
- Scenario 1, basic vote: issue, press cand[2] cleanly, press cast -> voter=4'b0100 for 7 cycles, confirm high for exactly 3 cycles starting 2 cycles after voter valid; vote_done pulse; ballots_cast=1; ready=1.
- Scenario 2, bounce rejection: cand[1] toggled every 2 cycles for 20 cycles, then held high -> sel_led stays 0 during bouncing, becomes 4'b0010 after 4 stable synchronized cycles.
- Scenario 3, invalid inputs: in IDLE press cand[0] and cast -> no confirm. In ARMED press cand[0] and cand[3] in the same debounced cycle -> sel_led=0. Cast with sel=0 -> no confirm.
- Scenario 4, cancel and atomicity: armed with sel=4'b1000, cancel -> IDLE, no confirm. Second vote: assert cancel and ballot_issue during STROBE -> transaction completes, ballots_cast increments by 1.
- Scenario 5, saturation and reset: cast 256 votes -> ballots_cast=255. Assert rst during STROBE -> confirm=0, voter=0, ballots_cast=0 asynchronously.
- Scenario 6, timeout (BALLOT_TIMEOUT_EN, TIMEOUT=50): issue ballot and idle 50 cycles -> timeout_flag pulse, ready=1. A candidate press at cycle 40 extends expiry by 50 cycles from that press.
